// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI-Lite response codes, controller states and command/response records
package axi_lite_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } ctrl_state_e;

    typedef struct packed {
        logic                    write;
        logic [AXI_ADDR_W-1:0]   addr;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
    } cmd_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            resp;
        logic                  timeout;
    } rsp_t;
endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// axi_lite_timeout_ctr: counts idle response-wait cycles and flags the cycle that would reach the limit
module axi_lite_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [W-1:0] cnt;

    // expiry fires on the idle cycle whose increment would bring the count to the limit
    assign expired = (TIMEOUT_CYCLES > 0) && enable && cnt == LAST;

    // count waiting cycles, restart whenever the controller is outside a response phase
    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/axi_lite_master_ctrl.sv
// axi_lite_master_ctrl: one-at-a-time AXI-Lite master with response watchdog and late-response drain
module axi_lite_master_ctrl
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                busy,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);
    ctrl_state_e         state, state_d;
    logic                drain_b, drain_b_d, drain_r, drain_r_d;
    logic                cmd_ready_d, rsp_valid_d, rsp_timeout_d, busy_d;
    logic                awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
    logic [ADDR_W-1:0]   awaddr_d, araddr_d;
    logic [DATA_W-1:0]   wdata_d, rsp_rdata_d;
    logic [DATA_W/8-1:0] wstrb_d;
    logic [1:0]          rsp_resp_d;
    logic                wd_clear, wd_enable, wd_expired;

    assign wd_clear  = !(state == WR_RESP || state == RD_RESP);
    assign wd_enable = (state == WR_RESP && !bvalid) || (state == RD_RESP && !rvalid);

    axi_lite_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // next state and next value of every registered output
    always_comb begin
        state_d       = state;
        awaddr_d      = awaddr;
        araddr_d      = araddr;
        wdata_d       = wdata;
        wstrb_d       = wstrb;
        awvalid_d     = awvalid;
        wvalid_d      = wvalid;
        arvalid_d     = arvalid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        drain_b_d     = drain_b && !(bvalid && bready && state != WR_RESP);
        drain_r_d     = drain_r && !(rvalid && rready && state != RD_RESP);
        case (state)
            IDLE: if (cmd_valid && cmd_ready) begin
                awaddr_d  = cmd_addr;
                araddr_d  = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                awvalid_d = cmd_write;
                wvalid_d  = cmd_write;
                arvalid_d = !cmd_write;
                state_d   = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                awvalid_d = awvalid && !awready;
                wvalid_d  = wvalid && !wready;
                state_d   = (!awvalid_d && !wvalid_d) ? WR_RESP : WR_REQ;
            end
            RD_REQ: begin
                arvalid_d = arvalid && !arready;
                state_d   = arvalid_d ? RD_REQ : RD_RESP;
            end
            WR_RESP: if (bvalid) begin
                rsp_rdata_d   = '0;
                rsp_resp_d    = bresp;
                rsp_timeout_d = 1'b0;
                state_d       = RSP;
            end else if (wd_expired) begin
                rsp_rdata_d   = '0;
                rsp_resp_d    = SLVERR;
                rsp_timeout_d = 1'b1;
                drain_b_d     = 1'b1;
                state_d       = RSP;
            end
            RD_RESP: if (rvalid) begin
                rsp_rdata_d   = rdata;
                rsp_resp_d    = rresp;
                rsp_timeout_d = 1'b0;
                state_d       = RSP;
            end else if (wd_expired) begin
                rsp_rdata_d   = '0;
                rsp_resp_d    = SLVERR;
                rsp_timeout_d = 1'b1;
                drain_r_d     = 1'b1;
                state_d       = RSP;
            end
            RSP: state_d = rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
        bready_d    = state_d == WR_RESP || drain_b_d;
        rready_d    = state_d == RD_RESP || drain_r_d;
        rsp_valid_d = state_d == RSP;
        cmd_ready_d = state_d == IDLE && !drain_b_d && !drain_r_d;
        busy_d      = state_d != IDLE || drain_b_d || drain_r_d;
    end

    // register state, drain flags and all outputs; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            drain_b     <= 1'b0;
            drain_r     <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            awaddr      <= '0;
            araddr      <= '0;
            wdata       <= '0;
            wstrb       <= '1;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            arvalid     <= 1'b0;
            bready      <= 1'b0;
            rready      <= 1'b0;
        end else begin
            state       <= state_d;
            drain_b     <= drain_b_d;
            drain_r     <= drain_r_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_resp    <= rsp_resp_d;
            rsp_timeout <= rsp_timeout_d;
            busy        <= busy_d;
            awaddr      <= awaddr_d;
            araddr      <= araddr_d;
            wdata       <= wdata_d;
            wstrb       <= wstrb_d;
            awvalid     <= awvalid_d;
            wvalid      <= wvalid_d;
            arvalid     <= arvalid_d;
            bready      <= bready_d;
            rready      <= rready_d;
        end
    end
endmodule
